// File: rtl/comet_ii_fetch_unit.sv
// COMET II fetch stage: owns the PC, issues one-word program-memory reads over a
// req/ack handshake and hands the returned word to the core FSM.
module comet_ii_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic        mclk,
    input  logic        rst,
    input  logic        init,
    input  logic        fetch,
    input  logic        jump,
    input  logic [15:0] jump_addr,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] rdata,
    output logic        rdata_valid,
    output logic [15:0] pc,
    output logic        busy,
    output logic        fault
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Last counter value reached while still waiting; no ack on that edge means timeout.
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t      state_r;
    logic [15:0] pc_r;
    logic [15:0] mem_addr_r;
    logic        mem_rd_r;
    logic [15:0] rdata_r;
    logic        rdata_valid_r;
    logic        busy_r;
    logic        fault_r;
    logic [7:0]  wait_cnt_r;
    logic        jump_pending_r;
    logic [15:0] jump_target_r;

    // Fetch FSM: PC, memory request, returned word and timeout fault.
    always_ff @(posedge mclk) begin
        if (rst) begin
            state_r        <= IDLE;
            pc_r           <= RESET_PC;
            mem_addr_r     <= 16'h0000;
            mem_rd_r       <= 1'b0;
            rdata_r        <= 16'h0000;
            rdata_valid_r  <= 1'b0;
            busy_r         <= 1'b0;
            fault_r        <= 1'b0;
            wait_cnt_r     <= 8'd0;
            jump_pending_r <= 1'b0;
            jump_target_r  <= 16'h0000;
        end else begin
            rdata_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    // A late ack arriving here is deliberately ignored.
                    if (init) begin
                        pc_r           <= RESET_PC;
                        fault_r        <= 1'b0;
                        jump_pending_r <= 1'b0;
                    end else if (fetch && !fault_r) begin
                        mem_addr_r     <= jump ? jump_addr : pc_r;
                        mem_rd_r       <= 1'b1;
                        busy_r         <= 1'b1;
                        wait_cnt_r     <= 8'd0;
                        jump_pending_r <= 1'b0;
                        state_r        <= WAIT;
                        if (jump) begin
                            pc_r <= jump_addr;
                        end else begin
                            pc_r <= pc_r;
                        end
                    end else if (jump) begin
                        pc_r <= jump_addr;
                    end else begin
                        pc_r <= pc_r;
                    end
                end
                WAIT: begin
                    if (init) begin
                        // Abort outranks a same-cycle ack; its data is dropped.
                        mem_rd_r       <= 1'b0;
                        busy_r         <= 1'b0;
                        pc_r           <= RESET_PC;
                        fault_r        <= 1'b0;
                        jump_pending_r <= 1'b0;
                        state_r        <= IDLE;
                    end else if (mem_ack) begin
                        rdata_r        <= mem_rdata;
                        rdata_valid_r  <= 1'b1;
                        mem_rd_r       <= 1'b0;
                        busy_r         <= 1'b0;
                        jump_pending_r <= 1'b0;
                        state_r        <= IDLE;
                        if (jump) begin
                            pc_r <= jump_addr;
                        end else if (jump_pending_r) begin
                            pc_r <= jump_target_r;
                        end else begin
                            pc_r <= mem_addr_r + 16'd1;
                        end
                    end else if (wait_cnt_r == LAST_WAIT) begin
                        mem_rd_r       <= 1'b0;
                        busy_r         <= 1'b0;
                        fault_r        <= 1'b1;
                        jump_pending_r <= 1'b0;
                        state_r        <= IDLE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 8'd1;
                        if (jump) begin
                            jump_target_r  <= jump_addr;
                            jump_pending_r <= 1'b1;
                        end else begin
                            jump_target_r  <= jump_target_r;
                        end
                    end
                end
                default: begin
                    state_r        <= IDLE;
                    mem_rd_r       <= 1'b0;
                    busy_r         <= 1'b0;
                    jump_pending_r <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr    = mem_addr_r;
    assign mem_rd      = mem_rd_r;
    assign rdata       = rdata_r;
    assign rdata_valid = rdata_valid_r;
    assign pc          = pc_r;
    assign busy        = busy_r;
    assign fault       = fault_r;

endmodule

// File: tb/tb_comet_ii_fetch_unit.sv
// Directed bench for comet_ii_fetch_unit: a cycle-by-cycle vector table plus
// hand-written timeout and reset-during-fetch sequences.
module tb_comet_ii_fetch_unit;

    logic        mclk = 1'b0;
    logic        rst, init, fetch, jump, mem_ack;
    logic [15:0] jump_addr, mem_rdata;
    logic [15:0] mem_addr, rdata, pc;
    logic        mem_rd, rdata_valid, busy, fault;

    int total = 0;
    int bad   = 0;

    comet_ii_fetch_unit #(.RESET_PC(16'h0000), .TIMEOUT(15)) dut (
        .mclk(mclk), .rst(rst), .init(init), .fetch(fetch), .jump(jump),
        .jump_addr(jump_addr), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .rdata(rdata),
        .rdata_valid(rdata_valid), .pc(pc), .busy(busy), .fault(fault)
    );

    always #5 mclk = ~mclk;

    typedef struct {
        logic        init, fetch, jump;
        logic [15:0] jaddr;
        logic        ack;
        logic [15:0] mdata;
        logic        e_rd;
        logic [15:0] e_addr, e_rdata;
        logic        e_rv;
        logic [15:0] e_pc;
        logic        e_busy, e_fault;
    } vec_t;

    vec_t vecs[27];

    function automatic vec_t mk(input logic i, input logic f, input logic j, input logic [15:0] ja,
                                input logic a, input logic [15:0] md, input logic erd,
                                input logic [15:0] ead, input logic [15:0] erdata, input logic erv,
                                input logic [15:0] epc, input logic eb, input logic ef);
        vec_t v;
        v.init = i; v.fetch = f; v.jump = j; v.jaddr = ja; v.ack = a; v.mdata = md;
        v.e_rd = erd; v.e_addr = ead; v.e_rdata = erdata; v.e_rv = erv;
        v.e_pc = epc; v.e_busy = eb; v.e_fault = ef;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic check_all(input string tag, input logic erd, input logic [15:0] ead,
                             input logic [15:0] erdata, input logic erv, input logic [15:0] epc,
                             input logic eb, input logic ef);
        check({tag, ".mem_rd"},      {15'd0, mem_rd},      {15'd0, erd});
        check({tag, ".mem_addr"},    mem_addr,             ead);
        check({tag, ".rdata"},       rdata,                erdata);
        check({tag, ".rdata_valid"}, {15'd0, rdata_valid}, {15'd0, erv});
        check({tag, ".pc"},          pc,                   epc);
        check({tag, ".busy"},        {15'd0, busy},        {15'd0, eb});
        check({tag, ".fault"},       {15'd0, fault},       {15'd0, ef});
    endtask

    task automatic drive(input logic i, input logic f, input logic j, input logic [15:0] ja,
                         input logic a, input logic [15:0] md);
        init = i; fetch = f; jump = j; jump_addr = ja; mem_ack = a; mem_rdata = md;
    endtask

    task automatic step;
        @(posedge mclk);
        #1;
    endtask

    initial begin
        //              init fetch jump jaddr   ack data     rd  addr     rdata    rv  pc       busy flt
        vecs[0]  = mk(0, 1, 0, 16'h0000, 0, 16'h0000,  1, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0);
        vecs[1]  = mk(0, 0, 0, 16'h0000, 1, 16'hA000,  0, 16'h0000, 16'hA000, 1, 16'h0001, 0, 0);
        vecs[2]  = mk(0, 0, 0, 16'h0000, 0, 16'h0000,  0, 16'h0000, 16'hA000, 0, 16'h0001, 0, 0);
        vecs[3]  = mk(0, 1, 0, 16'h0000, 0, 16'h0000,  1, 16'h0001, 16'hA000, 0, 16'h0001, 1, 0);
        vecs[4]  = mk(0, 0, 0, 16'h0000, 0, 16'h0000,  1, 16'h0001, 16'hA000, 0, 16'h0001, 1, 0);
        vecs[5]  = mk(0, 0, 0, 16'h0000, 0, 16'h0000,  1, 16'h0001, 16'hA000, 0, 16'h0001, 1, 0);
        vecs[6]  = mk(0, 0, 0, 16'h0000, 1, 16'hB001,  0, 16'h0001, 16'hB001, 1, 16'h0002, 0, 0);
        vecs[7]  = mk(0, 1, 0, 16'h0000, 1, 16'hDEAD,  1, 16'h0002, 16'hB001, 0, 16'h0002, 1, 0);
        vecs[8]  = mk(0, 0, 0, 16'h0000, 1, 16'hC002,  0, 16'h0002, 16'hC002, 1, 16'h0003, 0, 0);
        vecs[9]  = mk(0, 0, 1, 16'hFFFF, 0, 16'h0000,  0, 16'h0002, 16'hC002, 0, 16'hFFFF, 0, 0);
        vecs[10] = mk(0, 1, 0, 16'h0000, 0, 16'h0000,  1, 16'hFFFF, 16'hC002, 0, 16'hFFFF, 1, 0);
        vecs[11] = mk(0, 0, 0, 16'h0000, 1, 16'h1111,  0, 16'hFFFF, 16'h1111, 1, 16'h0000, 0, 0);
        vecs[12] = mk(0, 0, 1, 16'h0010, 0, 16'h0000,  0, 16'hFFFF, 16'h1111, 0, 16'h0010, 0, 0);
        vecs[13] = mk(0, 1, 0, 16'h0000, 0, 16'h0000,  1, 16'h0010, 16'h1111, 0, 16'h0010, 1, 0);
        vecs[14] = mk(0, 0, 1, 16'h1234, 0, 16'h0000,  1, 16'h0010, 16'h1111, 0, 16'h0010, 1, 0);
        vecs[15] = mk(0, 0, 0, 16'h0000, 1, 16'h2222,  0, 16'h0010, 16'h2222, 1, 16'h1234, 0, 0);
        vecs[16] = mk(0, 1, 0, 16'h0000, 0, 16'h0000,  1, 16'h1234, 16'h2222, 0, 16'h1234, 1, 0);
        vecs[17] = mk(0, 0, 0, 16'h0000, 1, 16'h3333,  0, 16'h1234, 16'h3333, 1, 16'h1235, 0, 0);
        vecs[18] = mk(0, 1, 1, 16'h0050, 0, 16'h0000,  1, 16'h0050, 16'h3333, 0, 16'h0050, 1, 0);
        vecs[19] = mk(0, 0, 0, 16'h0000, 1, 16'h4444,  0, 16'h0050, 16'h4444, 1, 16'h0051, 0, 0);
        vecs[20] = mk(0, 1, 0, 16'h0000, 0, 16'h0000,  1, 16'h0051, 16'h4444, 0, 16'h0051, 1, 0);
        vecs[21] = mk(1, 0, 0, 16'h0000, 1, 16'h5555,  0, 16'h0051, 16'h4444, 0, 16'h0000, 0, 0);
        vecs[22] = mk(0, 0, 0, 16'h0000, 0, 16'h0000,  0, 16'h0051, 16'h4444, 0, 16'h0000, 0, 0);
        vecs[23] = mk(0, 1, 0, 16'h0000, 0, 16'h0000,  1, 16'h0000, 16'h4444, 0, 16'h0000, 1, 0);
        vecs[24] = mk(0, 1, 0, 16'h0000, 0, 16'h0000,  1, 16'h0000, 16'h4444, 0, 16'h0000, 1, 0);
        vecs[25] = mk(0, 0, 0, 16'h0000, 1, 16'h6666,  0, 16'h0000, 16'h6666, 1, 16'h0001, 0, 0);
        vecs[26] = mk(1, 1, 1, 16'h0777, 0, 16'h0000,  0, 16'h0000, 16'h6666, 0, 16'h0000, 0, 0);

        rst = 1'b1;
        drive(0, 0, 0, 16'h0000, 0, 16'h0000);
        step();
        step();
        check_all("reset", 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0);
        rst = 1'b0;

        for (int k = 0; k < 27; k++) begin
            drive(vecs[k].init, vecs[k].fetch, vecs[k].jump, vecs[k].jaddr, vecs[k].ack, vecs[k].mdata);
            step();
            check_all($sformatf("vec%0d", k), vecs[k].e_rd, vecs[k].e_addr, vecs[k].e_rdata,
                      vecs[k].e_rv, vecs[k].e_pc, vecs[k].e_busy, vecs[k].e_fault);
        end

        // Timeout: request stays up for exactly 15 cycles, then fault.
        drive(0, 1, 0, 16'h0000, 0, 16'h0000);
        step();
        check_all("to_issue", 1, 16'h0000, 16'h6666, 0, 16'h0000, 1, 0);
        drive(0, 0, 0, 16'h0000, 0, 16'h0000);
        for (int k = 0; k < 13; k++) begin
            step();
            check_all($sformatf("to_wait%0d", k), 1, 16'h0000, 16'h6666, 0, 16'h0000, 1, 0);
        end
        step();
        check_all("to_last", 1, 16'h0000, 16'h6666, 0, 16'h0000, 1, 0);
        step();
        check_all("to_fault", 0, 16'h0000, 16'h6666, 0, 16'h0000, 0, 1);
        drive(0, 1, 0, 16'h0000, 0, 16'h0000);
        step();
        check_all("fault_fetch_ignored", 0, 16'h0000, 16'h6666, 0, 16'h0000, 0, 1);
        drive(0, 0, 0, 16'h0000, 1, 16'h7777);
        step();
        check_all("fault_late_ack", 0, 16'h0000, 16'h6666, 0, 16'h0000, 0, 1);
        drive(1, 0, 0, 16'h0000, 0, 16'h0000);
        step();
        check_all("init_clears_fault", 0, 16'h0000, 16'h6666, 0, 16'h0000, 0, 0);
        drive(0, 0, 0, 16'h0000, 1, 16'h8888);
        step();
        check_all("idle_late_ack", 0, 16'h0000, 16'h6666, 0, 16'h0000, 0, 0);

        // Reset in the middle of a fetch wins over a same-cycle ack.
        drive(0, 0, 1, 16'h4000, 0, 16'h0000);
        step();
        drive(0, 1, 0, 16'h0000, 0, 16'h0000);
        step();
        check_all("pre_rst_wait", 1, 16'h4000, 16'h6666, 0, 16'h4000, 1, 0);
        rst = 1'b1;
        drive(0, 0, 0, 16'h0000, 1, 16'h9999);
        step();
        check_all("rst_mid_wait", 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0);
        rst = 1'b0;
        drive(0, 0, 0, 16'h0000, 0, 16'h0000);
        step();
        check_all("post_rst_idle", 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/comet_ii_fetch_unit.md
Name: comet_ii_fetch_unit

Overview:
Program-counter and instruction-word fetch stage sitting directly upstream of the COMET II core FSM.
- Owns the PC and issues one-word reads to program memory over a req/ack handshake.
- Presents the returned word on rdata, which the core FSM latches into IR1 or IR2.
- Handles jump redirection, init re-entry and a memory-timeout fault.

Parameters:
RESET_PC, 16'h0000, PC value loaded on rst and on init.
TIMEOUT, 15, max cycles in WAIT without mem_ack before fault (1..255).

Ports:
mclk  input  1  system clock, all logic on posedge.
rst  input  1  synchronous active-high reset.
init  input  1  one-cycle pulse: reload PC with RESET_PC, abort any fetch, clear fault.
fetch  input  1  one-cycle request for the word at PC.
jump  input  1  one-cycle pulse: redirect PC to jump_addr.
jump_addr  input  16  jump target.
mem_addr  output  16  memory word address.
mem_rd  output  1  read request, held until ack.
mem_ack  input  1  memory returns mem_rdata this cycle.
mem_rdata  input  16  memory read data.
rdata  output  16  last fetched word, stable until the next completed fetch.
rdata_valid  output  1  one-cycle pulse: rdata updated.
pc  output  16  current program counter.
busy  output  1  high while in WAIT.
fault  output  1  sticky memory-timeout flag.

Behaviour:
Reset (rst high at posedge):
- state=IDLE, pc=RESET_PC, mem_addr=0, mem_rd=0, rdata=0, rdata_valid=0, busy=0, fault=0, wait counter=0, jump_pending=0.
- rst overrides all other inputs.

States: IDLE, WAIT.

Defaults: rdata_valid is 0 every cycle unless explicitly pulsed.

IDLE:
- init: pc<=RESET_PC, fault<=0. Same-cycle fetch and jump are ignored.
- jump without fetch: pc<=jump_addr.
- fetch with fault=0: mem_addr<=(jump ? jump_addr : pc), mem_rd<=1, busy<=1, counter<=0, state<=WAIT. If jump is also asserted, pc<=jump_addr.
- fetch with fault=1: ignored, no memory request.
- mem_ack is ignored (late ack after abort or timeout).

WAIT (mem_rd=1, mem_addr held constant):
- mem_ack=1:
  - rdata<=mem_rdata, rdata_valid<=1 (next cycle).
  - mem_rd<=0, busy<=0, state<=IDLE.
  - pc<=jump_pending ? jump_addr_latched : mem_addr+1, mod 2^16 (FFFF wraps to 0000). jump_pending<=0.
- jump during WAIT: latch jump_addr, jump_pending<=1. The later of multiple jumps wins. The in-flight word is still delivered.
- fetch during WAIT: ignored (no queueing).
- init during WAIT: abort. mem_rd<=0, busy<=0, pc<=RESET_PC, fault<=0, jump_pending<=0, state<=IDLE, no rdata_valid. Init wins over a same-cycle mem_ack, whose data is discarded.
- Timeout: the counter increments each WAIT cycle without ack. When counter==TIMEOUT-1 and still no ack: mem_rd<=0, busy<=0, fault<=1, state<=IDLE. pc and rdata unchanged.

Latency:
- fetch accepted at edge N gives mem_rd=1 after edge N.
- Zero-wait ack sampled at edge N+1 gives rdata_valid=1 after edge N+1.
- Back-to-back issue: the next fetch is accepted at edge N+2.

Core interface: rdata is stable from completion until the next completed fetch, so the core's negedge capture always sees a settled value.

Test Plan:
- Reset, then fetch with zero-wait memory returning A000 at address 0000 -> mem_rd high one cycle, mem_addr=0000; rdata=A000 with rdata_valid pulse one cycle after ack; pc=0001, busy=0.
- Fetch with ack delayed 3 cycles -> mem_rd and mem_addr=pc held 3 cycles; single rdata_valid; pc increments by exactly 1.
- pc=FFFF, fetch and ack -> pc=0000, no fault.
- jump_addr=1234 during WAIT at pc=0010 -> word from 0010 delivered; pc=1234 afterward; next fetch drives mem_addr=1234 and pc ends at 1235.
- No ack for TIMEOUT=15 cycles -> mem_rd drops, fault=1, fetch ignored afterward. Init clears fault, pc=RESET_PC; a late ack in IDLE produces no rdata_valid.
- init coincident with mem_ack in WAIT -> no rdata_valid, rdata unchanged, pc=RESET_PC. rst mid-WAIT -> all outputs return to their reset values the next cycle.
